alu_rs_scheduler: RTL and testbench
===================================

ALU_RS_SCHEDULER -- requirements
Module: alu_rs_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of reservation-station entries (age field is 3 bits, so DEPTH is at most 8).
REQ-002 SHALL have parameter TAG_W, default 8, physical-register tag width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 disp_valid  input  1  dispatch offers one entry.
REQ-006 disp_ready  output  1  scheduler accepts the offered entry.
REQ-007 disp_data  input  alu_rs_data  entry payload; its valid and age fields are ignored.
REQ-008 wb0_valid / wb0_tag  input  1 / TAG_W  writeback broadcast port 0.
REQ-009 wb1_valid / wb1_tag  input  1 / TAG_W  writeback broadcast port 1.
REQ-010 flush  input  1  mispredict flush; discard all contents.
REQ-011 issue_valid  output  1  the issue register holds an instruction.
REQ-012 issue_ready  input  1  the ALU consumes the issue register this cycle.
REQ-013 issue_data  output  alu_rs_data  the issued instruction, with both ready bits set.
REQ-014 occupancy  output  4  number of valid RS entries; excludes the issue register.

Function
REQ-015 An allocation SHALL occur on a rising edge when disp_valid && disp_ready; the entry is written into the lowest-index free slot.
REQ-016 disp_ready SHALL be 1 when occupancy < DEPTH and flush is 0; a full RS does not accept a same-cycle refill.
REQ-017 A wakeup SHALL set pr1_ready (pr2_ready) of every valid entry whose pr1 (pr2) equals wbX_tag while wbX_valid is asserted.
REQ-018 The same wakeup SHALL apply to disp_data in its allocation cycle, so the stored ready bits include that cycle's broadcasts.
REQ-019 Age SHALL equal the number of valid entries older than the entry, so ages are unique values 0..occupancy-1.
REQ-020 A new entry SHALL get age = occupancy after any same-cycle removal.
REQ-021 When an entry is removed, every entry with a larger age SHALL decrement its age by 1.
REQ-022 An entry SHALL be eligible for selection when it is valid, both ready bits are set, and it was not allocated in the current cycle.
REQ-023 Select SHALL pick the eligible entry with minimum age, i.e. the oldest ready entry.
REQ-024 The issue register SHALL load when it is empty or (issue_valid && issue_ready); the selected entry moves into it and is removed from the RS.
REQ-025 issue_data SHALL be held stable while issue_valid && !issue_ready.
REQ-026 Throughput SHALL be one issue per cycle when issue_ready is held high.
REQ-027 Allocation, removal, and wakeup SHALL all be able to occur on the same edge.
REQ-028 flush SHALL clear every entry and the issue register at the next edge.
REQ-029 flush SHALL override allocation, select, and wakeup.
REQ-030 In the flush cycle, issue_valid SHALL still reflect the register contents; the ALU discards by rob_index.

Reset
REQ-031 While rst_n = 0: all entries invalid, issue_valid = 0, issue_data = 0, occupancy = 0, disp_ready = 0.
REQ-032 Assertion of rst_n mid-operation SHALL discard all state immediately, without waiting for a clock edge.
REQ-033 disp_ready SHALL be 1 from the first cycle after rst_n deasserts.

Configuration
REQ-034 Macro ALU_RS_SAME_CYCLE_WAKEUP_EN: when defined, a broadcast in cycle N makes the entry eligible in cycle N (issue_valid at N+1).
REQ-035 When ALU_RS_SAME_CYCLE_WAKEUP_EN is not defined, eligibility SHALL use registered ready bits only (issue_valid at N+2).

Structure
REQ-036 alu_rs_data, an RS_DEPTH constant, and a wakeup-port typedef (valid, tag) SHALL live in types_pkg.
REQ-037 The oldest-ready selector SHALL be the sub-module alu_rs_select (eligible vector plus ages in, one-hot grant plus found out).

Verification
REQ-038 Reset, then dispatch A (both ready) at cycle 1 with issue_ready=1 -> issue_valid=1 at cycle 3 with issue_data=A, occupancy returns to 0.
REQ-039 Dispatch A (pr1=8'd20, not ready) then B (ready); broadcast wb0_tag=20 while B is issuing -> B issues first, then A, and A's pr1_ready=1.
REQ-040 Fill 8 entries with issue_ready=0 -> occupancy=8, disp_ready=0; a further disp_valid is not accepted; release issue_ready -> issue order follows age 0..7.
REQ-041 Entry pr1=5, pr2=6; wb0_tag=5 and wb1_tag=6 in the same cycle -> issue_valid at N+1 with the macro, N+2 without.
REQ-042 Hold issue_ready=0 for 5 cycles with the issue register full -> issue_data is unchanged throughout.
REQ-043 Assert flush with 4 entries valid and the issue register full, plus a simultaneous disp_valid -> next cycle occupancy=0, issue_valid=0, no allocation.

Source files
------------

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared types and constants for the ALU reservation-station scheduler
package types_pkg;

  localparam int RS_DEPTH  = 8;
  localparam int PKG_TAG_W = 8;

  // One reservation-station entry; also the format of the issued instruction.
  typedef struct packed {
    logic                 valid;
    logic [2:0]           age;
    logic [3:0]           op;
    logic [PKG_TAG_W-1:0] pd;
    logic [PKG_TAG_W-1:0] pr1;
    logic                 pr1_ready;
    logic [PKG_TAG_W-1:0] pr2;
    logic                 pr2_ready;
    logic [5:0]           rob_index;
  } alu_rs_data;

  // One writeback broadcast port.
  typedef struct packed {
    logic                 valid;
    logic [PKG_TAG_W-1:0] tag;
  } wb_port_t;

  // True when the broadcast port carries a valid tag equal to the source tag.
  function automatic logic tag_hit(input wb_port_t port, input logic [PKG_TAG_W-1:0] tag);
    return port.valid && (port.tag == tag);
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// rtl/alu_rs_select.sv - oldest-ready selector: picks the eligible entry with the smallest age
module alu_rs_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]      eligible,
  input  logic [DEPTH-1:0][2:0] ages,
  output logic [DEPTH-1:0]      grant,
  output logic                  found
);

  logic [2:0] best_age;

  // Linear scan keeping the smallest age seen so far; ages are unique so the winner is unique.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    best_age = 3'd7;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!found || (ages[i] < best_age))) begin
        found    = 1'b1;
        best_age = ages[i];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// rtl/alu_rs_scheduler.sv - ALU reservation station with wakeup, oldest-ready select and issue register (option: ALU_RS_SAME_CYCLE_WAKEUP_EN)
module alu_rs_scheduler
  import types_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int TAG_W = PKG_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  alu_rs_data       disp_data,
  input  logic             wb0_valid,
  input  logic [TAG_W-1:0] wb0_tag,
  input  logic             wb1_valid,
  input  logic [TAG_W-1:0] wb1_tag,
  input  logic             flush,
  output logic             issue_valid,
  input  logic             issue_ready,
  output alu_rs_data       issue_data,
  output logic [3:0]       occupancy
);

  alu_rs_data ent_q [DEPTH];
  logic       issue_valid_q;
  alu_rs_data issue_q;

  wb_port_t              wb0;
  wb_port_t              wb1;
  logic [DEPTH-1:0]      hit1;
  logic [DEPTH-1:0]      hit2;
  logic [DEPTH-1:0]      eligible;
  logic [DEPTH-1:0]      grant;
  logic [DEPTH-1:0]      alloc_oh;
  logic [DEPTH-1:0][2:0] ages;
  logic                  found;
  logic                  free_found;
  logic                  load_en;
  logic                  remove_en;
  logic                  alloc_en;
  logic [3:0]            occ;
  logic [3:0]            new_age_full;
  logic [2:0]            sel_age;
  alu_rs_data            sel_data;
  alu_rs_data            new_entry;
  alu_rs_data            issue_next;

  assign wb0.valid = wb0_valid;
  assign wb0.tag   = wb0_tag;
  assign wb1.valid = wb1_valid;
  assign wb1.tag   = wb1_tag;

  // Per-entry tag match against both broadcast ports, and selection eligibility.
  always_comb begin
    hit1     = '0;
    hit2     = '0;
    eligible = '0;
    ages     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = tag_hit(wb0, ent_q[i].pr1) | tag_hit(wb1, ent_q[i].pr1);
      hit2[i] = tag_hit(wb0, ent_q[i].pr2) | tag_hit(wb1, ent_q[i].pr2);
      ages[i] = ent_q[i].age;
`ifdef ALU_RS_SAME_CYCLE_WAKEUP_EN
      eligible[i] = ent_q[i].valid & (ent_q[i].pr1_ready | hit1[i]) & (ent_q[i].pr2_ready | hit2[i]);
`else
      eligible[i] = ent_q[i].valid & ent_q[i].pr1_ready & ent_q[i].pr2_ready;
`endif
    end
  end

  alu_rs_select #(.DEPTH(DEPTH)) u_select (
    .eligible (eligible),
    .ages     (ages),
    .grant    (grant),
    .found    (found)
  );

  // Occupancy count, lowest free slot, and the granted entry's payload and age.
  always_comb begin
    occ        = '0;
    alloc_oh   = '0;
    free_found = 1'b0;
    sel_data   = '0;
    sel_age    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + {3'b000, ent_q[i].valid};
      if (!ent_q[i].valid && !free_found) begin
        alloc_oh[i] = 1'b1;
        free_found  = 1'b1;
      end
      if (grant[i]) begin
        sel_data = ent_q[i];
        sel_age  = ent_q[i].age;
      end
    end
  end

  // A full RS refuses dispatch even if an entry leaves on the same edge.
  assign disp_ready   = rst_n & ~flush & (occ < 4'(DEPTH));
  assign alloc_en     = disp_valid & disp_ready;
  assign load_en      = ~issue_valid_q | issue_ready;
  assign remove_en    = load_en & found;
  assign new_age_full = occ - {3'b000, remove_en};

  // Incoming entry picks up this cycle's broadcasts; issued entry leaves with both sources ready.
  always_comb begin
    new_entry           = disp_data;
    new_entry.valid     = 1'b1;
    new_entry.age       = new_age_full[2:0];
    new_entry.pr1_ready = disp_data.pr1_ready | tag_hit(wb0, disp_data.pr1) | tag_hit(wb1, disp_data.pr1);
    new_entry.pr2_ready = disp_data.pr2_ready | tag_hit(wb0, disp_data.pr2) | tag_hit(wb1, disp_data.pr2);
    issue_next           = sel_data;
    issue_next.valid     = 1'b1;
    issue_next.age       = 3'd0;
    issue_next.pr1_ready = 1'b1;
    issue_next.pr2_ready = 1'b1;
  end

  // Entry array: removal, age compaction, wakeup and allocation, with flush overriding all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid) begin
          if (remove_en && grant[i]) begin
            ent_q[i].valid <= 1'b0;
          end else begin
            if (hit1[i]) ent_q[i].pr1_ready <= 1'b1;
            if (hit2[i]) ent_q[i].pr2_ready <= 1'b1;
            if (remove_en && (ent_q[i].age > sel_age)) ent_q[i].age <= ent_q[i].age - 3'd1;
          end
        end else if (alloc_en && alloc_oh[i]) begin
          ent_q[i] <= new_entry;
        end
      end
    end
  end

  // Issue register: refills whenever empty or being consumed, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
    end else if (flush) begin
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
    end else if (load_en) begin
      issue_valid_q <= found;
      if (found) issue_q <= issue_next;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_data  = issue_q;
  assign occupancy   = occ;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb/tb_alu_rs_scheduler.sv - self-checking bench for alu_rs_scheduler against a queue-based model
module tb_alu_rs_scheduler;
  import types_pkg::*;

  localparam int DEPTH = RS_DEPTH;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       disp_valid;
  logic       disp_ready;
  alu_rs_data disp_data;
  logic       wb0_valid;
  logic [7:0] wb0_tag;
  logic       wb1_valid;
  logic [7:0] wb1_tag;
  logic       flush;
  logic       issue_valid;
  logic       issue_ready;
  alu_rs_data issue_data;
  logic [3:0] occupancy;

  int checks   = 0;
  int failures = 0;

  // Model: RS contents in age order (front = oldest), plus the issue register.
  alu_rs_data mq[$];
  bit         m_iv;
  alu_rs_data m_issue;

  alu_rs_scheduler #(.DEPTH(DEPTH), .TAG_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_data   (disp_data),
    .wb0_valid   (wb0_valid),
    .wb0_tag     (wb0_tag),
    .wb1_valid   (wb1_valid),
    .wb1_tag     (wb1_tag),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_data  (issue_data),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic alu_rs_data mk(input logic [3:0] op, input logic [7:0] pd,
                                    input logic [7:0] p1, input logic r1,
                                    input logic [7:0] p2, input logic r2,
                                    input logic [5:0] rob);
    alu_rs_data d;
    d = '0;
    d.valid = 1'b1;
    d.op = op; d.pd = pd;
    d.pr1 = p1; d.pr1_ready = r1;
    d.pr2 = p2; d.pr2_ready = r2;
    d.rob_index = rob;
    return d;
  endfunction

  function automatic bit mhit(input logic [7:0] t);
    return (wb0_valid && wb0_tag == t) || (wb1_valid && wb1_tag == t);
  endfunction

  function automatic bit melig(input alu_rs_data e);
`ifdef ALU_RS_SAME_CYCLE_WAKEUP_EN
    return (e.pr1_ready || mhit(e.pr1)) && (e.pr2_ready || mhit(e.pr2));
`else
    return e.pr1_ready && e.pr2_ready;
`endif
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_update();
    bit         dr;
    bit         load;
    int         sel;
    alu_rs_data e;
    dr = (mq.size() < DEPTH) && !flush;
    if (flush) begin
      mq.delete();
      m_iv = 1'b0;
      return;
    end
    load = !m_iv || issue_ready;
    sel = -1;
    if (load) begin
      for (int i = 0; i < mq.size(); i++)
        if (sel < 0 && melig(mq[i])) sel = i;
    end
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      if (mhit(e.pr1)) e.pr1_ready = 1'b1;
      if (mhit(e.pr2)) e.pr2_ready = 1'b1;
      mq[i] = e;
    end
    if (load) begin
      if (sel >= 0) begin
        e = mq[sel];
        e.pr1_ready = 1'b1;
        e.pr2_ready = 1'b1;
        m_issue = e;
        mq.delete(sel);
        m_iv = 1'b1;
      end else begin
        m_iv = 1'b0;
      end
    end
    if (disp_valid && dr) begin
      e = disp_data;
      e.valid = 1'b1;
      e.age = 3'd0;
      if (mhit(e.pr1)) e.pr1_ready = 1'b1;
      if (mhit(e.pr2)) e.pr2_ready = 1'b1;
      mq.push_back(e);
    end
  endtask

  // Called at a falling edge after inputs are driven: compare, advance model, wait one cycle.
  task automatic step();
    #1;
    check("issue_valid", 64'(issue_valid), 64'(m_iv));
    if (m_iv) check("issue_data", 64'(issue_data), 64'(m_issue));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("disp_ready", 64'(disp_ready), 64'(((mq.size() < DEPTH) && !flush) ? 1 : 0));
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    disp_data  = '0;
    wb0_valid  = 1'b0;
    wb0_tag    = '0;
    wb1_valid  = 1'b0;
    wb1_tag    = '0;
    flush      = 1'b0;
  endtask

  task automatic drain(input int n);
    idle();
    issue_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic dispatch(input alu_rs_data d);
    idle();
    disp_valid = 1'b1;
    disp_data  = d;
    step();
  endtask

  alu_rs_data a_d, b_d, x_d;

  initial begin
    rst_n = 1'b0;
    issue_ready = 1'b0;
    idle();
    m_iv = 1'b0;
    m_issue = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_issue_valid", 64'(issue_valid), 64'd0);
    check("reset_issue_data", 64'(issue_data), 64'd0);
    check("reset_occupancy", 64'(occupancy), 64'd0);
    check("reset_disp_ready", 64'(disp_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ready instruction: issue_valid two cycles after dispatch.
    issue_ready = 1'b1;
    a_d = mk(4'h3, 8'd40, 8'd1, 1'b1, 8'd2, 1'b1, 6'd11);
    dispatch(a_d);
    check("t1_occ_after_alloc", 64'(occupancy), 64'd1);
    check("t1_iv_after_alloc", 64'(issue_valid), 64'd0);
    idle();
    step();
    check("t1_iv", 64'(issue_valid), 64'd1);
    check("t1_data", 64'(issue_data), 64'(a_d));
    check("t1_occ_drained", 64'(occupancy), 64'd0);
    drain(2);

    // Younger ready entry overtakes older one waiting on tag 20.
    a_d = mk(4'h1, 8'd50, 8'd20, 1'b0, 8'd3, 1'b1, 6'd21);
    b_d = mk(4'h2, 8'd51, 8'd4, 1'b1, 8'd5, 1'b1, 6'd22);
    dispatch(a_d);
    dispatch(b_d);
    idle();
    wb0_valid = 1'b1;
    wb0_tag = 8'd20;
    step();
`ifdef ALU_RS_SAME_CYCLE_WAKEUP_EN
    check("t2_first_rob", 64'(issue_data.rob_index), 64'd21);
    check("t2_first_pr1_ready", 64'(issue_data.pr1_ready), 64'd1);
    idle();
    step();
    check("t2_second_rob", 64'(issue_data.rob_index), 64'd22);
`else
    check("t2_first_rob", 64'(issue_data.rob_index), 64'd22);
    idle();
    step();
    check("t2_second_rob", 64'(issue_data.rob_index), 64'd21);
    check("t2_second_pr1_ready", 64'(issue_data.pr1_ready), 64'd1);
`endif
    drain(3);

    // Fill the RS behind a stalled issue register, then release in age order.
    issue_ready = 1'b0;
    for (int k = 0; k < 9; k++) dispatch(mk(4'h4, 8'(k), 8'd100, 1'b1, 8'd101, 1'b1, 6'(k)));
    idle();
    check("t3_occ_full", 64'(occupancy), 64'd8);
    disp_valid = 1'b1;
    disp_data = mk(4'h5, 8'd9, 8'd100, 1'b1, 8'd101, 1'b1, 6'd15);
    #1;
    check("t3_disp_ready_full", 64'(disp_ready), 64'd0);
    step();
    check("t3_occ_no_refill", 64'(occupancy), 64'd8);
    idle();
    issue_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check("t3_order_iv", 64'(issue_valid), 64'd1);
      check("t3_order_rob", 64'(issue_data.rob_index), 64'(k));
      step();
    end
    drain(2);

    // Two sources woken by both ports in the same cycle.
    dispatch(mk(4'h6, 8'd60, 8'd5, 1'b0, 8'd6, 1'b0, 6'd33));
    idle();
    wb0_valid = 1'b1; wb0_tag = 8'd5;
    wb1_valid = 1'b1; wb1_tag = 8'd6;
    step();
`ifdef ALU_RS_SAME_CYCLE_WAKEUP_EN
    check("t4_iv_n1", 64'(issue_valid), 64'd1);
`else
    check("t4_iv_n1", 64'(issue_valid), 64'd0);
    idle();
    step();
    check("t4_iv_n2", 64'(issue_valid), 64'd1);
`endif
    drain(3);

    // Stalled issue register must hold its payload.
    issue_ready = 1'b0;
    x_d = mk(4'h7, 8'd70, 8'd7, 1'b1, 8'd8, 1'b1, 6'd44);
    dispatch(x_d);
    idle();
    step();
    dispatch(mk(4'h8, 8'd71, 8'd9, 1'b1, 8'd10, 1'b1, 6'd45));
    for (int k = 0; k < 5; k++) begin
      idle();
      step();
      check("t5_hold_iv", 64'(issue_valid), 64'd1);
      check("t5_hold_data", 64'(issue_data), 64'(x_d));
    end
    drain(4);

    // Flush with four entries, full issue register and a simultaneous dispatch.
    issue_ready = 1'b0;
    for (int k = 0; k < 5; k++) dispatch(mk(4'h9, 8'(80 + k), 8'd11, 1'b1, 8'd12, 1'b1, 6'(50 + k)));
    idle();
    check("t6_occ_before", 64'(occupancy), 64'd4);
    flush = 1'b1;
    disp_valid = 1'b1;
    disp_data = mk(4'ha, 8'd90, 8'd11, 1'b1, 8'd12, 1'b1, 6'd60);
    #1;
    check("t6_iv_in_flush", 64'(issue_valid), 64'd1);
    check("t6_disp_ready_flush", 64'(disp_ready), 64'd0);
    step();
    check("t6_occ_after", 64'(occupancy), 64'd0);
    check("t6_iv_after", 64'(issue_valid), 64'd0);
    drain(2);

    // Asynchronous reset between clock edges.
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) dispatch(mk(4'hb, 8'd91, 8'd13, 1'b1, 8'd14, 1'b1, 6'(k)));
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_areset_occ", 64'(occupancy), 64'd0);
    check("t7_areset_iv", 64'(issue_valid), 64'd0);
    check("t7_areset_data", 64'(issue_data), 64'd0);
    check("t7_areset_disp_ready", 64'(disp_ready), 64'd0);
    mq.delete();
    m_iv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drain(1);

    // Randomized traffic with narrow tag range so wakeups collide often.
    for (int n = 0; n < 600; n++) begin
      disp_valid = ($urandom_range(0, 2) != 0);
      disp_data = mk(4'($urandom), 8'($urandom), 8'($urandom_range(0, 7)), 1'($urandom),
                     8'($urandom_range(0, 7)), 1'($urandom), 6'($urandom));
      disp_data.valid = 1'($urandom);
      disp_data.age = 3'($urandom);
      wb0_valid = ($urandom_range(0, 2) == 0);
      wb0_tag = 8'($urandom_range(0, 7));
      wb1_valid = ($urandom_range(0, 3) == 0);
      wb1_tag = 8'($urandom_range(0, 7));
      issue_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
    drain(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
